// File: rtl/jt51_lfo_lfsr_chk.sv
// Self-synchronising checker for the jt51 LFO noise LFSR: rebuilds the 19-bit
// generator window from the serial noise bit, predicts each next bit and tracks lock.
module jt51_lfo_lfsr_chk #(
  parameter int MATCH_N = 8,
  parameter int ERR_MAX = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             base,
  input  logic             din,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             valid,
  output logic [18:0]      word
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       RUN_LAST  = 8'(MATCH_N - 1);
  localparam logic [3:0]       MISS_LAST = 4'(ERR_MAX - 1);
  localparam logic [4:0]       FILL_LAST = 5'd18;
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  state_t     state;
  logic       last_base;
  logic [4:0] fill;
  logic [7:0] run;
  logic [3:0] miss;

  logic step;
  logic pred;
  logic hit;
  logic err_now;

  // Either edge of base is one LFSR step; prediction comes from the pre-shift window.
  assign step = base ^ last_base;
  assign pred = word[0] ^ word[1] ^ word[14] ^ word[15] ^ word[17] ^ word[18];
  assign hit  = (din == pred);

  // An all-zero window is treated as a failure so a stuck-zero stream never locks.
  assign err_now = step && (((state == CHECK) && !(hit && (word != '0))) ||
                            ((state == LOCKED) && !hit));

  // NOTE: every register below uses non-blocking assignment so all of them
  // see the same pre-edge values of word/state; blocking here would let the
  // prediction read the already-shifted window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HUNT;
      last_base <= 1'b0;
      fill      <= '0;
      run       <= '0;
      miss      <= '0;
      word      <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      valid     <= 1'b0;
    end else begin
      last_base <= base;
      valid     <= step;
      err       <= err_now;

      if (err_now && (err_cnt != CNT_SAT))
        err_cnt <= err_cnt + CNT_W'(1);

      if (step) begin
        word <= {word[17:0], din};
        unique case (state)
          HUNT: begin
            if (fill == FILL_LAST) begin
              fill  <= fill + 5'd1;
              run   <= '0;
              state <= CHECK;
            end else begin
              fill <= fill + 5'd1;
            end
          end
          CHECK: begin
            if (hit && (word != '0)) begin
              if (run == RUN_LAST) begin
                run    <= run + 8'd1;
                miss   <= '0;
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                run <= run + 8'd1;
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            if (hit) begin
              miss <= '0;
            end else if (miss == MISS_LAST) begin
              miss   <= miss + 4'd1;
              fill   <= '0;
              state  <= HUNT;
              locked <= 1'b0;
            end else begin
              miss <= miss + 4'd1;
            end
          end
          default: begin
            state  <= HUNT;
            fill   <= '0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt51_lfo_lfsr_chk.sv
// Bench for jt51_lfo_lfsr_chk: a reference LFSR drives din, a behavioural checker model
// pushes expected outputs per step to a scoreboard, popped when the DUT reports valid.
module tb_jt51_lfo_lfsr_chk;

  logic clk = 1'b0;
  logic rst_n;
  logic base;
  logic din;

  logic        locked,   err,   valid;
  logic [15:0] err_cnt;
  logic [18:0] word;
  logic        locked_s, err_s, valid_s;
  logic [1:0]  err_cnt_s;
  logic [18:0] word_s;

  jt51_lfo_lfsr_chk dut (
    .clk(clk), .rst_n(rst_n), .base(base), .din(din),
    .locked(locked), .err(err), .err_cnt(err_cnt), .valid(valid), .word(word)
  );

  // Narrow counter variant sharing the same stimulus, to exercise saturation.
  jt51_lfo_lfsr_chk #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .base(base), .din(din),
    .locked(locked_s), .err(err_s), .err_cnt(err_cnt_s), .valid(valid_s), .word(word_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] word;
    logic        err;
    logic        locked;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [18:0] gen;
  logic [18:0] m_word;
  int          m_state, m_fill, m_run, m_miss, m_cnt, m_cnt_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic gen_next();
    logic b;
    b   = gen[18];
    gen = {gen[17:0], gen[0] ^ gen[1] ^ gen[14] ^ gen[15] ^ gen[17] ^ gen[18]};
    return b;
  endfunction

  task automatic model_reset();
    m_word = '0; m_state = 0; m_fill = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_cnt_s = 0;
    sb.delete();
  endtask

  // Behavioural checker model: 0 = hunting, 1 = checking, 2 = locked.
  task automatic model_step(input logic d);
    logic p;
    logic e;
    exp_t x;
    e = 1'b0;
    p = m_word[0] ^ m_word[1] ^ m_word[14] ^ m_word[15] ^ m_word[17] ^ m_word[18];
    case (m_state)
      0: begin
        m_fill++;
        if (m_fill == 19) begin m_state = 1; m_run = 0; end
      end
      1: begin
        if (d == p && m_word != 0) begin
          m_run++;
          if (m_run == 8) begin m_state = 2; m_miss = 0; end
        end else begin
          e = 1'b1; m_run = 0;
        end
      end
      default: begin
        if (d == p) m_miss = 0;
        else begin
          e = 1'b1; m_miss++;
          if (m_miss == 3) begin m_state = 0; m_fill = 0; end
        end
      end
    endcase
    if (e) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end
    m_word   = {m_word[17:0], d};
    x.word   = m_word;
    x.err    = e;
    x.locked = (m_state == 2);
    x.cnt    = 16'(m_cnt);
    x.cnt_s  = 2'(m_cnt_s);
    sb.push_back(x);
  endtask

  // Called at a negedge: toggles base with the new bit, then spends gap cycles.
  task automatic step(input logic d, input int gap);
    exp_t x;
    bit   seen;
    seen = 0;
    base = ~base;
    din  = d;
    model_step(d);
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      if (valid) seen = 1;
    end
    check("valid", {31'd0, valid}, 32'd1);
    check("valid_s", {31'd0, valid_s}, 32'd1);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check("word", {13'd0, word}, {13'd0, x.word});
      check("word_s", {13'd0, word_s}, {13'd0, x.word});
      check("err", {31'd0, err}, {31'd0, x.err});
      check("err_s", {31'd0, err_s}, {31'd0, x.err});
      check("locked", {31'd0, locked}, {31'd0, x.locked});
      check("locked_s", {31'd0, locked_s}, {31'd0, x.locked});
      check("err_cnt", {16'd0, err_cnt}, {16'd0, x.cnt});
      check("err_cnt_s", {30'd0, err_cnt_s}, {30'd0, x.cnt_s});
    end
    for (int c = 1; c < gap; c++) begin
      @(negedge clk);
      check("valid_idle", {31'd0, valid}, 32'd0);
      check("err_idle", {31'd0, err}, 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; base = 1'b0; din = 1'b0;
    @(negedge clk);
    check("rst_word", {13'd0, word}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("rst_err_cnt_s", {30'd0, err_cnt_s}, 32'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic b;
    logic [18:0] hold_word;
    logic [15:0] hold_cnt;
    rst_n = 1'b0; base = 1'b0; din = 1'b0;
    gen = 19'd220;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Clean stream: lock after 27 steps, a burst of back-to-back steps, no errors.
    for (int n = 1; n <= 2000; n++) begin
      step(gen_next(), (n > 1000 && n <= 1100) ? 1 : 4);
      if (n == 26) check("t1_locked_26", {31'd0, locked}, 32'd0);
      if (n == 27) check("t1_locked_27", {31'd0, locked}, 32'd1);
    end
    check("t1_err_cnt", {16'd0, err_cnt}, 32'd0);

    // Single flipped bit: taps 0 and 1 give two more consecutive errors, which drops lock.
    b = gen_next();
    step(~b, 4);
    check("t2_cnt_1", {16'd0, err_cnt}, 32'd1);
    check("t2_locked_1", {31'd0, locked}, 32'd1);
    step(gen_next(), 4);
    check("t2_cnt_2", {16'd0, err_cnt}, 32'd2);
    check("t2_locked_2", {31'd0, locked}, 32'd1);
    step(gen_next(), 4);
    check("t2_cnt_3", {16'd0, err_cnt}, 32'd3);
    check("t2_locked_3", {31'd0, locked}, 32'd0);
    check("t2_cnt_s_sat", {30'd0, err_cnt_s}, 32'd3);
    for (int n = 1; n <= 27; n++) begin
      step(gen_next(), 4);
      if (n == 26) check("t2_relock_26", {31'd0, locked}, 32'd0);
      if (n == 27) check("t2_relock_27", {31'd0, locked}, 32'd1);
    end

    // Three inverted bits, then a clean tail long enough to be locked again.
    for (int n = 0; n < 3; n++) begin
      b = gen_next();
      step(~b, 4);
      if (n == 0) check("t3_first_err_cnt", {16'd0, err_cnt}, 32'd4);
    end
    for (int n = 0; n < 60; n++) step(gen_next(), 4);
    check("t3_locked_tail", {31'd0, locked}, 32'd1);

    // base held constant: everything holds, valid stays low.
    hold_word = word;
    hold_cnt  = err_cnt;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("t5_valid", {31'd0, valid}, 32'd0);
      check("t5_word", {13'd0, word}, {13'd0, m_word});
      check("t5_err_cnt", {16'd0, err_cnt}, 32'(m_cnt));
      check("t5_locked", {31'd0, locked}, 32'd1);
    end
    check("t5_word_hold", {13'd0, word}, {13'd0, hold_word});
    check("t5_cnt_hold", {16'd0, err_cnt}, {16'd0, hold_cnt});

    // Reset while locked, then relock from the running generator.
    do_reset();
    for (int n = 1; n <= 27; n++) begin
      step(gen_next(), 4);
      if (n == 26) check("t6_relock_26", {31'd0, locked}, 32'd0);
      if (n == 27) check("t6_relock_27", {31'd0, locked}, 32'd1);
    end

    // Stuck-zero stream: no errors while hunting, one per step while checking, never locks.
    do_reset();
    for (int n = 1; n <= 100; n++) begin
      step(1'b0, 2);
      check("t4_never_locked", {31'd0, locked}, 32'd0);
      if (n == 19) check("t4_cnt_19", {16'd0, err_cnt}, 32'd0);
      if (n == 20) check("t4_cnt_20", {16'd0, err_cnt}, 32'd1);
    end
    check("t4_err_cnt", {16'd0, err_cnt}, 32'd81);
    check("t4_err_cnt_s_sat", {30'd0, err_cnt_s}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
